// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Posted-store FIFO between the core data port and the memory bus,
//            with a full stall and a word-granular load-hazard stall.
//            Optional tail merge enabled by STORE_BUFFER_MERGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic                       LoadReq,
  input  logic [AW-1:0]              DataAdr,
  input  logic [DW-1:0]              WriteData,
  output logic                       Stall,
  output logic                       bus_valid,
  output logic [AW-1:0]              bus_addr,
  output logic [DW-1:0]              bus_data,
  input  logic                       bus_ready,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW-1:0]    tail;
  logic             full;
  logic             pop;
  logic             push;
  logic             merge_hit;
  logic             store_stall;
  logic             load_hazard;
  logic [DEPTH-1:0] hit_vec;

  assign full      = (Count == FULL_COUNT);
  assign Empty     = (Count == '0);
  assign bus_valid = ~Empty;
  assign bus_addr  = addr_q[rp];
  assign bus_data  = data_q[rp];
  assign pop       = bus_valid & bus_ready;
  assign tail      = wp - PW'(1);

`ifdef STORE_BUFFER_MERGE_EN
  // A single-entry tail that is leaving this cycle cannot absorb the store.
  assign merge_hit = MemWrite & ~Empty
                   & (addr_q[tail][AW-1:2] == DataAdr[AW-1:2])
                   & ((Count >= CW'(2)) | ~pop);
`else
  assign merge_hit = 1'b0;
`endif

  assign push        = MemWrite & ~full & ~merge_hit;
  assign store_stall = MemWrite & full & ~merge_hit;

  // An entry is live when its distance from the head is below Count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [PW-1:0] offset;
    assign offset     = PW'(i) - rp;
    assign hit_vec[i] = ({1'b0, offset} < Count)
                      & (addr_q[i][AW-1:2] == DataAdr[AW-1:2]);
  end

  assign load_hazard = LoadReq & (|hit_vec);
  assign Stall       = store_stall | load_hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      Count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wp] <= DataAdr;
        data_q[wp] <= WriteData;
        wp         <= wp + PW'(1);
      end
      if (merge_hit) begin
        data_q[tail] <= WriteData;
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
      if (push && !pop) begin
        Count <= Count + CW'(1);
      end else if (pop && !push) begin
        Count <= Count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Scoreboard bench for store_buffer; honours STORE_BUFFER_MERGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          MemWrite = 1'b0;
  logic          LoadReq = 1'b0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0;
  logic          bus_ready = 1'b0;
  logic          Stall;
  logic          bus_valid;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic [CW-1:0] Count;
  logic          Empty;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .LoadReq(LoadReq),
    .DataAdr(DataAdr), .WriteData(WriteData), .Stall(Stall),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_ready(bus_ready), .Count(Count), .Empty(Empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted bus beat must match the oldest outstanding store.
  always @(negedge clk) begin
    if (reset && bus_valid && bus_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_drain", 64'(bus_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("drain_addr", 64'(bus_addr), 64'(exp_q[0].a));
        chk("drain_data", 64'(bus_data), 64'(exp_q[0].d));
        exp_q.delete(0);
      end
    end
  end

  task automatic cycle(input logic mw, input logic ld, input logic [AW-1:0] adr,
                       input logic [DW-1:0] wd, input logic rdy, output logic stalled);
    int   sz;
    logic full;
    logic pop;
    logic merge;
    logic haz;
    logic exp_stall;
    ent_t e;
    @(posedge clk);
    #1;
    MemWrite  = mw;
    LoadReq   = ld;
    DataAdr   = adr;
    WriteData = wd;
    bus_ready = rdy;
    #1;
    sz = exp_q.size();
    chk("count", 64'(Count), 64'(sz));
    chk("empty", 64'(Empty), 64'(sz == 0));
    chk("bus_valid", 64'(bus_valid), 64'(sz != 0));
    full  = (sz == DEPTH);
    pop   = (sz > 0) && rdy;
    merge = 1'b0;
`ifdef STORE_BUFFER_MERGE_EN
    if (mw && sz >= 1)
      merge = (exp_q[sz-1].a[AW-1:2] == adr[AW-1:2]) && (sz >= 2 || !pop);
`endif
    haz = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].a[AW-1:2] == adr[AW-1:2]) haz = 1'b1;
    exp_stall = (mw && full && !merge) || (ld && haz);
    chk("stall", 64'(Stall), 64'(exp_stall));
    if (merge) begin
      exp_q[sz-1].d = wd;
    end else if (mw && !full) begin
      e.a = adr;
      e.d = wd;
      exp_q.push_back(e);
    end
    stalled = mw && full && !merge;
  endtask

  task automatic drain(input int n);
    logic st;
    repeat (n) cycle(1'b0, 1'b0, '0, '0, 1'b1, st);
  endtask

  initial begin
    logic          st;
    logic          pend;
    logic          mw;
    logic          ld;
    logic          rdy;
    logic [AW-1:0] a;
    logic [AW-1:0] pa;
    logic [DW-1:0] d;
    logic [DW-1:0] pd;

    #7;
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_valid", 64'(bus_valid), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_data", 64'(bus_data), 64'd0);
    chk("rst_empty", 64'(Empty), 64'd1);
    chk("rst_stall", 64'(Stall), 64'd0);
    #5 reset = 1'b1;

    // Single store, immediate drain
    cycle(1'b1, 1'b0, 32'd100, 32'd25, 1'b1, st);
    drain(2);

    // Fill, stall a fifth store, then drain in order
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 32'(96 + 4*i), 32'(i + 1), 1'b0, st);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 32'd112, 32'd5, 1'b0, st);
      chk("full_stall_flag", 64'(st), 64'd1);
    end
    st = 1'b1;
    for (int i = 0; i < 4 && st; i++)
      cycle(1'b1, 1'b0, 32'd112, 32'd5, 1'b1, st);
    drain(6);

    // Simultaneous push and pop at Count=2
    cycle(1'b1, 1'b0, 32'd200, 32'd10, 1'b0, st);
    cycle(1'b1, 1'b0, 32'd204, 32'd11, 1'b0, st);
    cycle(1'b1, 1'b0, 32'd208, 32'd12, 1'b1, st);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, st);
    drain(4);

    // Load hazard, word-granular
    cycle(1'b1, 1'b0, 32'd100, 32'd9, 1'b0, st);
    cycle(1'b0, 1'b1, 32'd100, 32'd0, 1'b0, st);
    cycle(1'b0, 1'b1, 32'd102, 32'd0, 1'b0, st);
    cycle(1'b0, 1'b1, 32'd104, 32'd0, 1'b0, st);
    drain(3);

    // Same-word stores: merged or kept separate depending on build
    cycle(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, st);
    cycle(1'b1, 1'b0, 32'd100, 32'd25, 1'b0, st);
    cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, st);
    drain(4);

    // Asynchronous reset with three entries pending
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 32'(300 + 4*i), 32'(i + 40), 1'b0, st);
    @(posedge clk);
    #1;
    MemWrite = 1'b0; LoadReq = 1'b1; DataAdr = 32'd300; bus_ready = 1'b0;
    #1;
    chk("pre_rst_count", 64'(Count), 64'd3);
    chk("pre_rst_hazard", 64'(Stall), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 64'(Count), 64'd0);
    chk("mid_rst_valid", 64'(bus_valid), 64'd0);
    chk("mid_rst_addr", 64'(bus_addr), 64'd0);
    chk("mid_rst_data", 64'(bus_data), 64'd0);
    chk("mid_rst_stall", 64'(Stall), 64'd0);
    exp_q.delete();
    LoadReq = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;

    // Random traffic; a stalled store is held until accepted
    pend = 1'b0;
    pa   = '0;
    pd   = '0;
    for (int k = 0; k < 400; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      a   = 32'h100 + 32'($urandom_range(0, 5)) * 32'd4 + 32'($urandom_range(0, 3));
      d   = $urandom;
      if (pend) begin
        mw = 1'b1;
        ld = 1'b0;
        a  = pa;
        d  = pd;
      end else begin
        mw = 1'($urandom_range(0, 1));
        ld = !mw && ($urandom_range(0, 2) == 0);
      end
      cycle(mw, ld, a, d, rdy, st);
      pend = st;
      pa   = a;
      pd   = d;
    end
    drain(DEPTH + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
